// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        ModeAdd = 2'b00,
        ModeSub = 2'b01,
        ModeAcc = 2'b10,
        ModeClr = 2'b11
    } cla_mode_t;

    // Number of lookahead groups; a zero group size is rejected by cfg_ok.
    function automatic int unsigned ng(input int unsigned width, input int unsigned group);
        return (group == 0) ? 1 : width / group;
    endfunction

    // Elaboration check: width of at least 2, split into whole groups.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned group);
        return (width >= 2) && (group != 0) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: sum bits, group P/G and the carry into its MSB.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] x,
    input  logic [GROUP-1:0] y,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             grp_p,
    output logic             grp_g,
    output logic             c_msb
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Group propagate/generate; kept apart from the carries so they never depend on cin.
    always_comb begin
        logic t;
        grp_p = &p;
        grp_g = 1'b0;
        for (int j = 0; j < int'(GROUP); j++) begin
            t = g[j];
            for (int k = j + 1; k < int'(GROUP); k++) begin
                t = t & p[k];
            end
            grp_g = grp_g | t;
        end
    end

    // Per-bit carries as flat sum-of-products (lookahead, no ripple inside the group).
    always_comb begin
        logic t;
        for (int i = 0; i < int'(GROUP); i++) begin
            t = cin;
            for (int k = 0; k < i; k++) begin
                t = t & p[k];
            end
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++) begin
                    t = t & p[k];
                end
                c[i] = c[i] | t;
            end
        end
    end

    assign sum   = p ^ c;
    assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/accumulator with valid/ready on both sides.
// S1 holds the effective operands, S2 holds the registered result.
// Optional feature: define CLA_SATURATE_EN to clamp overflowing results to signed max/min.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GROUP = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         cin,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             sum,
    output logic                         cout,
    output logic                         ovf,
    output logic [ng(WIDTH, GROUP)-1:0]  grp_p,
    output logic [ng(WIDTH, GROUP)-1:0]  grp_g
);

    localparam int unsigned NG    = ng(WIDTH, GROUP);
    localparam bit          CfgOk = cfg_ok(WIDTH, GROUP);

    if (!CfgOk) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be >= 2 and a multiple of GROUP");
    end

    logic             s1_valid_q, s1_valid_d;
    logic             s1_wacc_q, s1_wacc_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic             s1_cin_q, s1_cin_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [NG-1:0]    grp_p_q, grp_p_d;
    logic [NG-1:0]    grp_g_q, grp_g_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             advance;
    logic             accept;
    logic [NG-1:0]    gp, gg, grp_c, c_msb;
    logic [WIDTH-1:0] sum_raw, sum_res;
    logic             cout_res, ovf_res;
    logic             unused_c_msb;

    // An acc-writing op in S1 blocks new beats until it has updated acc.
    assign advance  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || (advance && !s1_wacc_q);
    assign accept   = in_valid && in_ready;

    // Form effective operands at accept; otherwise hold or drain S1.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_wacc_d  = s1_wacc_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_cin_d   = s1_cin_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_wacc_d  = 1'b0;
            s1_x_d     = a;
            s1_y_d     = b;
            s1_cin_d   = cin;
            case (cla_mode_t'(mode))
                ModeSub: begin
                    s1_y_d   = ~b;
                    s1_cin_d = 1'b1;
                end
                ModeAcc: begin
                    s1_y_d    = acc_q;
                    s1_wacc_d = 1'b1;
                end
                ModeClr: begin
                    s1_x_d    = '0;
                    s1_y_d    = '0;
                    s1_cin_d  = 1'b0;
                    s1_wacc_d = 1'b1;
                end
                default: ;
            endcase
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .x     (s1_x_q[k*GROUP +: GROUP]),
            .y     (s1_y_q[k*GROUP +: GROUP]),
            .cin   (grp_c[k]),
            .sum   (sum_raw[k*GROUP +: GROUP]),
            .grp_p (gp[k]),
            .grp_g (gg[k]),
            .c_msb (c_msb[k])
        );
    end

    // Only the top group's MSB carry feeds overflow.
    assign unused_c_msb = ^c_msb;

    // Group carries ripple from one slice to the next.
    always_comb begin
        logic c;
        c = s1_cin_q;
        for (int k = 0; k < int'(NG); k++) begin
            grp_c[k] = c;
            c        = gg[k] | (gp[k] & c);
        end
        cout_res = c;
    end

    // Overflow and optional clamping of the raw sum.
    always_comb begin
        sum_res = sum_raw;
        ovf_res = c_msb[NG-1] ^ cout_res;
`ifdef CLA_SATURATE_EN
        if (ovf_res) begin
            sum_res = s1_x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // S2 captures the result on advance and empties when the consumer takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        grp_p_d     = grp_p_q;
        grp_g_d     = grp_g_q;
        if (advance) begin
            out_valid_d = 1'b1;
            sum_d       = sum_res;
            cout_d      = cout_res;
            ovf_d       = ovf_res;
            grp_p_d     = gp;
            grp_g_d     = gg;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        acc_d = (advance && s1_wacc_q) ? sum_res : acc_q;
    end

    // Stage S1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_wacc_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_cin_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_wacc_q  <= s1_wacc_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_cin_q   <= s1_cin_d;
        end
    end

    // Stage S2 result registers and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            grp_p_q     <= '0;
            grp_g_q     <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            grp_p_q     <= grp_p_d;
            grp_g_q     <= grp_g_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign grp_p     = grp_p_q;
    assign grp_g     = grp_g_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases plus randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_cla_pipe_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned G  = 4;
    localparam int unsigned NG = W / G;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

`ifdef CLA_SATURATE_EN
    localparam logic [W-1:0] OVF_SUM = 8'h7F;
`else
    localparam logic [W-1:0] OVF_SUM = 8'h80;
`endif

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [NG-1:0] p;
        logic [NG-1:0] g;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;

    int     n_checks = 0;
    int     n_fail   = 0;
    res_t   exp_q[$];
    res_t   obs_q[$];
    res_t   cur;
    res_t   e;
    logic [W-1:0] model_acc = '0;
    bit     rand_rdy = 1'b0;
    bit     stall_q  = 1'b0;
    int     idx;

    cla_pipe_adder #(
        .WIDTH (W),
        .GROUP (G)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .grp_p     (grp_p),
        .grp_g     (grp_g)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: plain W+1-bit addition of the effective operands.
    function automatic res_t ref_op(input logic [1:0] m, input logic [W-1:0] av,
                                    input logic [W-1:0] bv, input logic ci,
                                    input logic [W-1:0] accv);
        logic [W-1:0] x, y;
        logic         c;
        logic [W:0]   full;
        logic [G-1:0] xs, ys;
        logic [G:0]   gs;
        res_t         r;
        x = av;
        y = bv;
        c = ci;
        case (m)
            OP_SUB: begin y = ~bv; c = 1'b1; end
            OP_ACC: y = accv;
            OP_CLR: begin x = '0; y = '0; c = 1'b0; end
            default: ;
        endcase
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        for (int k = 0; k < int'(NG); k++) begin
            xs     = x[k*G +: G];
            ys     = y[k*G +: G];
            gs     = {1'b0, xs} + {1'b0, ys};
            r.p[k] = &(xs ^ ys);
            r.g[k] = gs[G];
        end
`ifdef CLA_SATURATE_EN
        if (r.ovf) r.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return r;
    endfunction

    // Scoreboard: model on accept, compare whatever S2 presents, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            cur = {sum, cout, ovf, grp_p, grp_g};
            if (stall_q) check_eq("hold_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("result", 32'(cur), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (out_ready) obs_q.push_back(cur);
            end
            stall_q = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                e = ref_op(mode, a, b, cin, model_acc);
                if (mode == OP_ACC || mode == OP_CLR) model_acc = e.sum;
                exp_q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        cin      = ci;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("drain", 32'(ok), 32'd1);
    endtask

    task automatic check_obs(input string tag, input int i, input res_t want);
        if (obs_q.size() <= i) check_eq(tag, 32'(obs_q.size()), 32'(i + 1));
        else check_eq(tag, 32'(obs_q[i]), 32'(want));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        check_eq("rst_grp", 32'({grp_p, grp_g}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with one-edge result latency.
        obs_q.delete();
        send(OP_ADD, 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        check_eq("lat_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_s2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();
        check_obs("add_0f_01", 0, {8'h10, 1'b0, 1'b0, 2'b00, 2'b01});

        // Signed overflow, then the two subtract cases.
        obs_q.delete();
        send(OP_ADD, 8'h7F, 8'h01, 1'b0);
        send(OP_SUB, 8'h05, 8'h07, 1'b0);
        send(OP_SUB, 8'h07, 8'h05, 1'b0);
        wait_idle();
        check_obs("add_ovf", 0, {OVF_SUM, 1'b0, 1'b1, 2'b00, 2'b01});
        check_obs("sub_borrow", 1, {8'hFE, 1'b0, 1'b0, 2'b10, 2'b00});
        check_obs("sub_noborrow", 2, {8'h02, 1'b1, 1'b0, 2'b10, 2'b01});

        // CLR then back-to-back ACC with in_valid held: one bubble after each.
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            mode     = (i == 0) ? OP_CLR : OP_ACC;
            a        = W'(i * 16);
            b        = W'($urandom);
            cin      = 1'b0;
            @(negedge clk);
            check_eq("acc_ir_hi", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("acc_ir_lo", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();
        check_obs("clr", 0, {8'h00, 1'b0, 1'b0, 2'b00, 2'b00});
        check_obs("acc_10", 1, {8'h10, 1'b0, 1'b0, 2'b00, 2'b00});
        check_obs("acc_30", 2, {8'h30, 1'b0, 1'b0, 2'b00, 2'b00});
        check_obs("acc_60", 3, {8'h60, 1'b0, 1'b0, 2'b00, 2'b00});

        // Consumer stalled for 5 cycles while 3 ADDs are offered.
        obs_q.delete();
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        mode      = OP_ADD;
        a         = 8'h01;
        b         = 8'h01;
        cin       = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 3) begin
                a = W'(idx + 1);
                b = W'(idx + 1);
            end else in_valid = 1'b0;
        end
        check_eq("stall_accepts", 32'(idx), 32'd2);
        @(negedge clk);
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_sum", 32'(sum), 32'h02);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 3; n++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            if (idx == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check_eq("stall_third", 32'(idx), 32'd3);
        wait_idle();
        check_obs("order_0", 0, {8'h02, 1'b0, 1'b0, 2'b00, 2'b00});
        check_obs("order_1", 1, {8'h04, 1'b0, 1'b0, 2'b00, 2'b00});
        check_obs("order_2", 2, {8'h06, 1'b0, 1'b0, 2'b00, 2'b00});

        // Randomized traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(OP_ADD, 8'h11, 8'h22, 1'b0);
        send(OP_ADD, 8'h33, 8'h44, 1'b0);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_sum", 32'(sum), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        obs_q.delete();
        model_acc = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(OP_ACC, 8'h05, W'($urandom), 1'b0);
        wait_idle();
        check_obs("acc_after_rst", 0, {8'h05, 1'b0, 1'b0, 2'b00, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/accumulator, the multi-bit successor to the single-bit propagate/generate full-adder cell. Operands are accepted over a valid/ready handshake. Group propagate/generate terms are computed per GROUP-bit slice. Sum, carry, overflow and group P/G are returned over a second valid/ready handshake. It sits between the pin-level wrapper's input decode and output mux, and supports add, subtract, accumulate and clear modes.

## Interface
- WIDTH, 8, operand/result width; ≥2.
- GROUP, 4, lookahead group size; must divide WIDTH; NG = WIDTH/GROUP.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored in ACC/CLR.
- cin  in  1  carry in; used in ADD and ACC only.
- mode  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; in SUB, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB xor carry out of MSB.
- grp_p  out  NG  group propagate of the effective operands.
- grp_g  out  NG  group generate of the effective operands.

## Operation
- Effective operands are formed at accept and registered in stage S1:
  - ADD: (a, b, cin).
  - SUB: (a, ~b, 1).
  - ACC: (a, acc, cin).
  - CLR: (0, 0, 0).
- Per bit: p = x^y, g = x&y. Group P = AND of bit p. Group G is the standard lookahead generate.
- Group carries ripple between groups; carries are lookahead within a group.
- Result stage S2 registers sum, cout, ovf, grp_p and grp_g, and sets out_valid.
- Internal register acc (WIDTH) is loaded with the S2 sum whenever an ACC or CLR op advances S1→S2. CLR always loads 0.
- Flow control:
  - advance = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || (advance && !s1_writes_acc), where s1_writes_acc = S1 holds ACC or CLR. This interlock gives acc-writing ops one-bubble throughput: one per 2 cycles.
  - in_ready never depends on in_valid or mode.
- While out_valid && !out_ready, all result outputs are held stable.
- Results are produced in accept order; no op is dropped or duplicated.
- Width rule: sum is the low WIDTH bits; carry beyond MSB appears only in cout.

## Timing
- Reset values: in_ready 1; out_valid 0; sum 0; cout 0; ovf 0; grp_p 0; grp_g 0; acc 0; S1 empty.
- Reset mid-operation discards in-flight beats immediately (asynchronous).
- Latency: beat accepted at edge N gives out_valid=1 after edge N+1 when S2 is free or drained at N+1.
- Throughput: 1 op/cycle for ADD/SUB; 1 op per 2 cycles for ACC/CLR.
- Full pipeline is S1 and S2 both valid with out_ready=0: in_ready=0.
- Simultaneous out_ready and in_valid on a full pipeline: S2 drains, S1 advances and a new beat enters on the same edge, except when S1 holds ACC/CLR.
- An ACC op immediately following an ACC/CLR op sees the updated acc.

## Configuration
- CLA_SATURATE_EN defined:
  - When ovf=1, sum (and acc for ACC) clamps to signed max 0x7F… if effective operand x MSB is 0, else signed min 0x80….
  - ovf still reports 1; cout is unchanged.
- CLA_SATURATE_EN undefined: wrap-around; sum is raw modulo 2^WIDTH.

## Structure
- Package cla_pkg holds:
  - typedef cla_mode_t enum for ADD/SUB/ACC/CLR encodings.
  - Function ng(WIDTH, GROUP).
  - Elaboration check constants for WIDTH%GROUP==0.
- Sub-module cla_group: one GROUP-bit lookahead slice. Inputs x, y, cin; outputs sum bits, group P, group G, carry into MSB. Instantiated NG times via generate.

## Test plan
(WIDTH=8, GROUP=4)
- ADD a=0x0F b=0x01 cin=0 -> after one edge: out_valid=1, sum=0x10, cout=0, ovf=0, grp_p=2'b00, grp_g=2'b01.
- ADD 0x7F+0x01 -> ovf=1; sum=0x80 without macro, 0x7F with CLA_SATURATE_EN.
- SUB 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; SUB 0x07-0x05 -> sum=0x02, cout=1.
- CLR, then back-to-back ACC a=0x10,0x20,0x30 with in_valid held -> sums 0x00,0x10,0x30,0x60; in_ready low exactly one cycle after each acc-writing accept.
- out_ready=0 for 5 cycles while 3 ADDs are offered -> only 2 accepted, in_ready=0, outputs stable; on release, results emerge in order.
- Assert rst_n=0 with S1 and S2 full -> out_valid, sum and acc read 0 immediately; in_ready=1; next ACC 0x05 returns 0x05.
